// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Brief    : Decode-to-EX issue control with a per-register write scoreboard,
//            RAW/WAW stall, drain and optional stall counter (PIPE_HAZARD_PERF_EN).
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int WB_LAT = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [31:0]      id_instr,
  input  logic             drain_req,
  output logic             stall,
  output logic             ex_valid,
  output logic [31:0]      ex_instr,
  output logic             idle,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [2:0] c_wb_lat   = 3'(WB_LAT);
  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_load  = 6'b100011;
  localparam logic [5:0] c_fn_add   = 6'b100000;
  localparam logic [5:0] c_fn_sub   = 6'b100010;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_is_rtype;
  logic        w_is_load;
  logic        w_reads_rs;
  logic        w_reads_rt;
  logic        w_writes;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_dest;
  logic [31:0] w_busy;
  logic        w_hazard;
  logic        w_issue;
  logic        w_unused_shamt;

  assign w_rs       = id_instr[25:21];
  assign w_rt       = id_instr[20:16];
  assign w_is_rtype = (id_instr[31:26] == c_op_rtype) &&
                      ((id_instr[5:0] == c_fn_add) || (id_instr[5:0] == c_fn_sub));
  assign w_is_load  = (id_instr[31:26] == c_op_load);
  assign w_reads_rs = w_is_rtype | w_is_load;
  assign w_reads_rt = w_is_rtype;
  assign w_writes   = w_is_rtype | w_is_load;
  assign w_dest     = w_is_rtype ? id_instr[15:11] : id_instr[20:16];
  assign w_unused_shamt = ^id_instr[10:6];

  assign w_hazard = id_valid & ((w_reads_rs & w_busy[w_rs]) |
                                (w_reads_rt & w_busy[w_rt]) |
                                (w_writes   & w_busy[w_dest]));
  assign w_issue  = id_valid & ~stall;

  // Per-register countdown; a fresh load wins over the decrement.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_sb
      if (gi == 0) begin : g_zero
        assign w_busy[gi] = 1'b0;
      end else begin : g_reg
        logic [2:0] r_cnt;
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            r_cnt <= 3'd0;
          end else if (w_issue && w_writes && (w_dest == 5'(gi))) begin
            r_cnt <= c_wb_lat;
          end else if (r_cnt != 3'd0) begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        assign w_busy[gi] = (r_cnt != 3'd0);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    stall       = w_hazard;
    case (r_state)
      ST_RUN:   w_state_nxt = w_hazard ? ST_STALL : ST_RUN;
      ST_STALL: w_state_nxt = w_hazard ? ST_STALL : ST_RUN;
      ST_DRAIN: begin
        stall       = 1'b1;
        w_state_nxt = w_hazard ? ST_STALL : ST_RUN;
      end
      default:  w_state_nxt = ST_RUN;
    endcase
    if (drain_req) begin
      w_state_nxt = ST_DRAIN;
    end
  end

  assign idle = (r_state == ST_DRAIN) && (w_busy == 32'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid <= 1'b0;
      ex_instr <= 32'd0;
    end else begin
      ex_valid <= w_issue;
      ex_instr <= w_issue ? id_instr : 32'd0;
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_W-1:0] r_stall_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_count <= '0;
    end else if ((r_state != ST_DRAIN) && stall && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign stall_count = r_stall_count;
`else
  assign stall_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Brief    : Directed plus randomized bench with a per-register cycle model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  localparam int c_wb_lat = 2;
  localparam int c_cnt_w  = 4;
  localparam int c_cnt_max = 15;

  logic               clk;
  logic               reset_n;
  logic               id_valid;
  logic [31:0]        id_instr;
  logic               drain_req;
  logic               stall;
  logic               ex_valid;
  logic [31:0]        ex_instr;
  logic               idle;
  logic [c_cnt_w-1:0] stall_count;

  pipeline_hazard_ctrl #(.WB_LAT(c_wb_lat), .CNT_W(c_cnt_w)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .drain_req  (drain_req),
    .stall      (stall),
    .ex_valid   (ex_valid),
    .ex_instr   (ex_instr),
    .idle       (idle),
    .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: cycles left before each register's write lands.
  int          pend [32];
  bit          m_drain;
  int          m_cnt;
  logic        m_exv;
  logic [31:0] m_exi;
  int          n_vec;
  int          n_fail;

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'b00000, fn};
  endfunction

  function automatic logic [31:0] load(input int rs, input int rt);
    return {6'b100011, 5'(rs), 5'(rt), 16'h0000};
  endfunction

  function automatic int exp_count();
`ifdef PIPE_HAZARD_PERF_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  function automatic logic [31:0] rand_instr();
    int k;
    logic [31:0] w;
    k = $urandom_range(0, 4);
    w = $urandom;
    case (k)
      0: return rtype($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), 6'b100000);
      1: return rtype($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), 6'b100010);
      2: return load($urandom_range(0, 4), $urandom_range(0, 4));
      3: return rtype($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), 6'b100100);
      default: return {6'b001000, w[25:0]};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < 32; r++) pend[r] = 0;
    m_drain = 1'b0;
    m_cnt   = 0;
    m_exv   = 1'b0;
    m_exi   = 32'h0;
  endtask

  // One clock cycle: drive, check combinational outputs, clock, check registers.
  task automatic step(input logic v, input logic [31:0] ins, input logic dr);
    bit rrs, rrt, wr, haz, st, iss, idl;
    int rs, rt, dest;
    id_valid  = v;
    id_instr  = ins;
    drain_req = dr;
    rrs = 0; rrt = 0; wr = 0; dest = 0;
    rs = int'(ins[25:21]);
    rt = int'(ins[20:16]);
    if (ins[31:26] == 6'd0 && (ins[5:0] == 6'd32 || ins[5:0] == 6'd34)) begin
      rrs = 1; rrt = 1; wr = 1; dest = int'(ins[15:11]);
    end else if (ins[31:26] == 6'd35) begin
      rrs = 1; wr = 1; dest = rt;
    end
    haz = v && ((rrs && pend[rs] > 0) || (rrt && pend[rt] > 0) || (wr && pend[dest] > 0));
    st  = m_drain || haz;
    iss = v && !st;
    idl = m_drain;
    for (int r = 0; r < 32; r++) if (pend[r] != 0) idl = 0;
    #2;
    check("stall", 32'(stall), 32'(st));
    check("idle", 32'(idle), 32'(idl));
    @(posedge clk);
    for (int r = 0; r < 32; r++) begin
      if (iss && wr && dest == r && r != 0) pend[r] = c_wb_lat;
      else if (pend[r] > 0) pend[r] = pend[r] - 1;
    end
    if (!m_drain && st && m_cnt < c_cnt_max) m_cnt++;
    m_drain = dr;
    m_exv = iss;
    m_exi = iss ? ins : 32'h0;
    #1;
    check("ex_valid", 32'(ex_valid), 32'(m_exv));
    check("ex_instr", ex_instr, m_exi);
    check("stall_count", 32'(stall_count), 32'(exp_count()));
  endtask

  // Asynchronous reset asserted between edges, checked before any clock.
  task automatic do_reset();
    id_valid  = 1'b1;
    id_instr  = rtype(3, 2, 4, 6'b100010);
    drain_req = 1'b0;
    reset_n   = 1'b0;
    #1;
    check("rst_ex_valid", 32'(ex_valid), 32'h0);
    check("rst_ex_instr", ex_instr, 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_idle", 32'(idle), 32'h0);
    check("rst_stall_count", 32'(stall_count), 32'h0);
    model_clear();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_fail = 0;
    model_clear();
    reset_n = 1'b0;
    id_valid = 1'b0;
    id_instr = 32'h0;
    drain_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // RAW: dependent SUB stalls WB_LAT cycles.
    step(1'b1, 32'h00221820, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, rtype(3, 2, 4, 6'b100010), 1'b0);
    check("raw_stall_count", 32'(stall_count), 32'(exp_count()));

    // Independent stream.
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    step(1'b1, rtype(1, 2, 3, 6'b100000), 1'b0);
    step(1'b1, rtype(1, 2, 4, 6'b100010), 1'b0);
    step(1'b1, rtype(1, 2, 5, 6'b100000), 1'b0);

    // LOAD and R0 destinations.
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h8C010000, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, rtype(1, 2, 5, 6'b100000), 1'b0);
    step(1'b1, rtype(1, 2, 0, 6'b100000), 1'b0);
    step(1'b1, rtype(0, 0, 6, 6'b100000), 1'b0);
    step(1'b1, load(2, 0), 1'b0);
    step(1'b1, rtype(0, 0, 0, 6'b100010), 1'b0);

    // Drain after issuing ADD R3, then release.
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h00221820, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, rtype(3, 2, 4, 6'b100010), 1'b1);
    step(1'b1, rtype(3, 2, 4, 6'b100010), 1'b0);
    step(1'b1, rtype(3, 2, 4, 6'b100010), 1'b0);

    // Reset mid-stream with R3 busy.
    step(1'b1, 32'h00221820, 1'b0);
    do_reset();
    step(1'b1, rtype(3, 2, 4, 6'b100010), 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic dr;
      dr = ($urandom_range(0, 19) == 0) ? 1'b1 : (m_drain && $urandom_range(0, 2) != 0);
      step(1'($urandom_range(0, 5) != 0), rand_instr(), dr);
    end

    // Saturation: 10 RAW pairs give 20 stall cycles.
    do_reset();
    for (int p = 0; p < 10; p++) begin
      step(1'b1, 32'h00221820, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, rtype(3, 2, 4, 6'b100010), 1'b0);
    end
`ifdef PIPE_HAZARD_PERF_EN
    check("sat_count", 32'(stall_count), 32'd15);
`else
    check("sat_count", 32'(stall_count), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
